// File: rtl/tan_arb_pkg.sv
// Shared types and default sizing for the tan engine request arbiter.
package tan_arb_pkg;

    localparam int unsigned DefN       = 4;
    localparam int unsigned DefW       = 16;
    localparam int unsigned DefTimeout = 255;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRelease,
        StBusy,
        StResp,
        StAbort
    } arb_state_e;

    // The watchdog counter must be able to hold the value TIMEOUT itself.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/tan_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping to 0.
module rr_pick
    import tan_arb_pkg::*;
#(
    parameter int unsigned N  = DefN,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    always_comb begin
        req2  = {req, req};
        // Rotate so rr_ptr lands on bit 0; the lowest set bit is then the winner.
        rot   = req2[rr_ptr +: N];
        any   = 1'b0;
        sum   = '0;
        grant = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum = {1'b0, rr_ptr} + (IW + 1)'(j);
                any = 1'b1;
            end
        end
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        grant = sum[IW-1:0];
    end

endmodule

// File: rtl/tan_req_arbiter.sv
// Shares one tan engine among N requesters: round-robin grant, start/done handshake,
// watchdog abort and one-hot response routing.
module tan_req_arbiter
    import tan_arb_pkg::*;
#(
    parameter int unsigned N       = DefN,
    parameter int unsigned W       = DefW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_x,
    output logic [N-1:0]   resp_valid,
    output logic [W-1:0]   resp_data,
    output logic           resp_err,
    output logic           busy,
    output logic           eng_start,
    output logic [W-1:0]   eng_x,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_result,
    output logic           eng_abort
);

    localparam int unsigned IW  = $clog2(N);
    localparam int unsigned WdW = wd_width(TIMEOUT);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  owner_inc;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic [W-1:0]   eng_x_q, eng_x_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_hit;

    logic [N-1:0]   resp_valid_q, resp_valid_d;
    logic [W-1:0]   resp_data_q, resp_data_d;
    logic           resp_err_q, resp_err_d;
    logic           busy_q, busy_d;
    logic           eng_start_q, eng_start_d;
    logic           eng_abort_q, eng_abort_d;

    logic [W-1:0]   req_x_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign req_x_arr[i] = req_x[i*W +: W];
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_idx),
        .any    (pick_any)
    );

    assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign wd_hit    = (wd_q + 1'b1) == WdW'(TIMEOUT);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        eng_x_d  = eng_x_q;
        wd_d     = wd_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any && eng_done) begin
                    owner_d = pick_idx;
                    eng_x_d = req_x_arr[pick_idx];
                    wd_d    = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StRelease;
            end
            StRelease: begin
                wd_d = wd_q + 1'b1;
                if (wd_hit) begin
                    state_d = StAbort;
                end else if (!eng_done) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                wd_d = wd_q + 1'b1;
                // A timeout takes priority over a completion seen on the same cycle.
                if (wd_hit) begin
                    state_d = StAbort;
                end else if (eng_done) begin
                    state_d = StResp;
                end
            end
            StResp, StAbort: begin
                rr_ptr_d = owner_inc;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d       = (state_d != StIdle);
        eng_start_d  = (state_d == StStart);
        eng_abort_d  = (state_d == StAbort);
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        if (state_d == StResp || state_d == StAbort) begin
            resp_valid_d = N'(1) << owner_d;
        end
        if (state_d == StResp) begin
            resp_data_d = eng_result;
        end
        if (state_d == StAbort) begin
            resp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            eng_x_q      <= '0;
            wd_q         <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            eng_x_q      <= eng_x_d;
            wd_q         <= wd_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            eng_start_q  <= eng_start_d;
            eng_abort_q  <= eng_abort_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign eng_start  = eng_start_q;
    assign eng_x      = eng_x_q;
    assign eng_abort  = eng_abort_q;

endmodule
